carry_alu_n: RTL and testbench
==============================

# carry_alu_n

Width-parametrised, slice-serial successor to the two-operand 8-bit carry ALU. Operands are processed in 4-bit carry slices, least significant first, one slice per enabled clock, so wide datapaths reuse a single CARRY4-sized adder and logic unit. It sits behind the same enable/strobe/write request interface and returns result, carry, zero and sign flags with a ready indication.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and at least 4; N = WIDTH/4 slices
- aclk  input  1  clock, all state on rising edge
- areset  input  1  asynchronous, active-high reset
- rx_enable  input  1  global enable; low freezes all state
- rx_strobe  input  1  request pulse; accepted only when idle and rx_enable=1
- rx_write  input  1  1: commit result to tx_result; 0: update flags only (compare/test)
- rx_carryflag  input  1  carry/borrow in for ADC/SBB
- rx_opcode  input  3  operation select
- rx_operand0  input  WIDTH  operand A
- rx_operand1  input  WIDTH  operand B
- tx_result  output  WIDTH  registered result
- tx_carryflag  output  1  carry out (ADD/ADC), borrow out (SUB/SBB), 0 for logic ops
- tx_zeroflag  output  1  full-width result == 0
- tx_signflag  output  1  result bit WIDTH-1
- tx_ready  output  1  1 when idle and able to accept

## Operation
- Opcodes: 000 ADD A+B; 001 ADC A+B+cin; 010 SUB A-B; 011 SBB A-B-cin; 100 AND; 101 OR; 110 XOR; 111 PASS B.
- SUB/SBB computed as A+~B+1 / A+~B+~cin; reported carry = inverted adder carry-out (borrow).
- States: IDLE, BUSY. Reset -> IDLE.
- IDLE, rx_enable=1, rx_strobe=1: latch operands, opcode, rx_write, rx_carryflag; slice counter <= 0; zero accumulator <= 1; go BUSY; tx_ready <= 0.
- BUSY, rx_enable=1: compute slice k from latched operands and the carry registered from slice k-1 (initial carry per opcode); store 4 result bits; zero accumulator &= (slice==0); k++.
- At slice N-1: update flags; if latched write=1 load tx_result, else tx_result holds; go IDLE; tx_ready <= 1.
- rx_enable=0: no state, counter or output changes in any state; strobes ignored.
- Strobe in BUSY ignored (no queueing). Inputs other than rx_enable are don't-care in BUSY.
- Reset values: tx_result 0, tx_carryflag 0, tx_zeroflag 0, tx_signflag 0, tx_ready 1; reset mid-operation aborts, nothing committed.
- Logic ops and PASS clear carry (and overflow when configured).

## Timing
- Acceptance edge t0; slices on edges t1..tN; outputs and tx_ready=1 visible after tN. Latency N+1 edges with rx_enable held high (WIDTH=16: 5).
- Each low-enable cycle during BUSY adds one cycle.
- Back-to-back: next strobe accepted on the first edge tx_ready=1 is sampled; throughput one operation per N+1 cycles.
- Outputs stable between completions; no combinational input-to-output paths.

## Configuration
- CARRY_ALU_OVERFLOW_EN defined: adds output tx_overflowflag (1 bit, reset 0) = signed overflow from the top slice (carry into bit WIDTH-1 XOR carry out) for ADD/ADC/SUB/SBB, 0 otherwise; updated with other flags.
- Undefined: port and logic absent; all other behaviour identical.

## Structure
- Package carry_alu_pkg: SLICE_W=4 constant, opcode enumeration, state enumeration (IDLE, BUSY).
- Sub-module carry_alu_slice: combinational 4-bit slice (a, b, cin, opcode -> y, cout, carry into MSB); instantiated once, time-multiplexed.

## Test plan
- WIDTH=16, ADD 0xFFFF+0x0001, write=1 -> tx_result 0x0000, carry 1, zero 1, sign 0; tx_ready low 5 cycles.
- SUB 0x0003-0x0005 -> 0xFFFE, carry(borrow) 1, sign 1, zero 0; SBB 0x1000-0x0001, cin=1 -> 0x0FFE, carry 0.
- ADC 0x00FF+0x0F01, cin=1 -> 0x1001, carry 0; cross-slice carry verified.
- Compare: write=0, SUB 0x1234-0x1234 -> zero 1, carry 0, tx_result retains prior value.
- rx_enable low 3 cycles mid-BUSY -> completion delayed exactly 3 cycles, same result; strobe during BUSY ignored; areset mid-BUSY -> all outputs reset values, tx_ready 1.
- With CARRY_ALU_OVERFLOW_EN: ADD 0x7FFF+0x0001 -> 0x8000, overflow 1, sign 1; XOR -> overflow 0.

Source files
------------

// File: rtl/carry_alu_pkg.sv
// Shared types for the slice-serial carry ALU: slice width, opcodes, FSM states.
// Optional overflow flag output is enabled by defining CARRY_ALU_OVERFLOW_EN.
package carry_alu_pkg;

    localparam int SLICE_W = 4;

    typedef enum logic [2:0] {
        OP_ADD  = 3'b000,
        OP_ADC  = 3'b001,
        OP_SUB  = 3'b010,
        OP_SBB  = 3'b011,
        OP_AND  = 3'b100,
        OP_OR   = 3'b101,
        OP_XOR  = 3'b110,
        OP_PASS = 3'b111
    } opcode_e;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_e;

    function automatic logic is_arith(input opcode_e op);
        return ~op[2];
    endfunction

    function automatic logic is_sub(input opcode_e op);
        return (op == OP_SUB) || (op == OP_SBB);
    endfunction

    // Carry fed into slice 0; subtraction is A + ~B + 1 (SUB) or A + ~B + ~cin (SBB).
    function automatic logic init_carry(input opcode_e op, input logic cin);
        case (op)
            OP_ADC:  return cin;
            OP_SUB:  return 1'b1;
            OP_SBB:  return ~cin;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/carry_alu_slice.sv
// Combinational 4-bit ALU slice; also exposes the carry into its MSB so the
// top slice can derive signed overflow.
module carry_alu_slice
    import carry_alu_pkg::*;
(
    input  logic [SLICE_W-1:0] i_a,
    input  logic [SLICE_W-1:0] i_b,
    input  logic               i_cin,
    input  opcode_e            i_opcode,
    output logic [SLICE_W-1:0] o_y,
    output logic               o_cout,
    output logic               o_cmsb
);

    logic [SLICE_W-1:0] w_b;
    logic [SLICE_W-1:0] w_lo;
    logic               w_c_msb;
    logic               w_sum_msb;
    logic               w_c_out;

    assign w_b       = is_sub(i_opcode) ? ~i_b : i_b;
    // Lower bits added one bit wider so the carry into the MSB falls out directly.
    assign w_lo      = {1'b0, i_a[SLICE_W-2:0]} + {1'b0, w_b[SLICE_W-2:0]} + SLICE_W'(i_cin);
    assign w_c_msb   = w_lo[SLICE_W-1];
    assign w_sum_msb = i_a[SLICE_W-1] ^ w_b[SLICE_W-1] ^ w_c_msb;
    assign w_c_out   = (i_a[SLICE_W-1] & w_b[SLICE_W-1]) |
                       (w_c_msb & (i_a[SLICE_W-1] ^ w_b[SLICE_W-1]));

    always_comb begin
        o_y    = '0;
        o_cout = 1'b0;
        o_cmsb = 1'b0;
        case (i_opcode)
            OP_ADD, OP_ADC, OP_SUB, OP_SBB: begin
                o_y    = {w_sum_msb, w_lo[SLICE_W-2:0]};
                o_cout = w_c_out;
                o_cmsb = w_c_msb;
            end
            OP_AND:  o_y = i_a & i_b;
            OP_OR:   o_y = i_a | i_b;
            OP_XOR:  o_y = i_a ^ i_b;
            default: o_y = i_b;
        endcase
    end

endmodule

// File: rtl/carry_alu_n.sv
// Slice-serial carry ALU: WIDTH/4 slices processed LSB first, one per enabled clock.
// Define CARRY_ALU_OVERFLOW_EN to add the tx_overflowflag output.
module carry_alu_n
    import carry_alu_pkg::*;
#(
    parameter int WIDTH = 16
) (
    input  logic             aclk,
    input  logic             areset,
    input  logic             rx_enable,
    input  logic             rx_strobe,
    input  logic             rx_write,
    input  logic             rx_carryflag,
    input  logic [2:0]       rx_opcode,
    input  logic [WIDTH-1:0] rx_operand0,
    input  logic [WIDTH-1:0] rx_operand1,
    output logic [WIDTH-1:0] tx_result,
    output logic             tx_carryflag,
    output logic             tx_zeroflag,
    output logic             tx_signflag,
`ifdef CARRY_ALU_OVERFLOW_EN
    output logic             tx_overflowflag,
`endif
    output logic             tx_ready
);

    localparam int N     = WIDTH / SLICE_W;
    localparam int CNT_W = (N > 1) ? $clog2(N) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(N - 1);

    state_e             r_state;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_a;
    logic [WIDTH-1:0]   r_b;
    opcode_e            r_op;
    logic               r_write;
    logic               r_carry;
    logic               r_zero;
    logic [WIDTH-1:0]   r_acc;
    logic [WIDTH-1:0]   r_result;
    logic               r_cflag;
    logic               r_zflag;
    logic               r_sflag;
    logic               r_ovflag;
    logic               r_ready;

    logic [SLICE_W-1:0]       w_y;
    logic                     w_cout;
    logic                     w_cmsb;
    logic [WIDTH+SLICE_W-1:0] w_acc_ext;
    logic [WIDTH-1:0]         w_acc_next;
    logic                     w_zero_next;

    carry_alu_slice u_slice (
        .i_a      (r_a[SLICE_W-1:0]),
        .i_b      (r_b[SLICE_W-1:0]),
        .i_cin    (r_carry),
        .i_opcode (r_op),
        .o_y      (w_y),
        .o_cout   (w_cout),
        .o_cmsb   (w_cmsb)
    );

    // Result bits enter at the top and shift down, so slice k lands at bits 4k+3:4k after N steps.
    assign w_acc_ext   = {w_y, r_acc};
    assign w_acc_next  = w_acc_ext[WIDTH+SLICE_W-1:SLICE_W];
    assign w_zero_next = r_zero & (w_y == '0);

    always_ff @(posedge aclk or posedge areset) begin
        if (areset) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_a      <= '0;
            r_b      <= '0;
            r_op     <= OP_ADD;
            r_write  <= 1'b0;
            r_carry  <= 1'b0;
            r_zero   <= 1'b1;
            r_acc    <= '0;
            r_result <= '0;
            r_cflag  <= 1'b0;
            r_zflag  <= 1'b0;
            r_sflag  <= 1'b0;
            r_ovflag <= 1'b0;
            r_ready  <= 1'b1;
        end else if (rx_enable) begin
            case (r_state)
                IDLE: begin
                    if (rx_strobe) begin
                        r_a     <= rx_operand0;
                        r_b     <= rx_operand1;
                        r_op    <= opcode_e'(rx_opcode);
                        r_write <= rx_write;
                        r_carry <= init_carry(opcode_e'(rx_opcode), rx_carryflag);
                        r_cnt   <= '0;
                        r_zero  <= 1'b1;
                        r_ready <= 1'b0;
                        r_state <= BUSY;
                    end
                end
                BUSY: begin
                    r_a     <= r_a >> SLICE_W;
                    r_b     <= r_b >> SLICE_W;
                    r_carry <= w_cout;
                    r_zero  <= w_zero_next;
                    r_acc   <= w_acc_next;
                    r_cnt   <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST) begin
                        if (r_write) begin
                            r_result <= w_acc_next;
                        end
                        r_cflag  <= is_sub(r_op) ? ~w_cout : w_cout;
                        r_zflag  <= w_zero_next;
                        r_sflag  <= w_y[SLICE_W-1];
                        r_ovflag <= is_arith(r_op) & (w_cmsb ^ w_cout);
                        r_ready  <= 1'b1;
                        r_state  <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign tx_result    = r_result;
    assign tx_carryflag = r_cflag;
    assign tx_zeroflag  = r_zflag;
    assign tx_signflag  = r_sflag;
    assign tx_ready     = r_ready;
`ifdef CARRY_ALU_OVERFLOW_EN
    assign tx_overflowflag = r_ovflag;
`else
    logic w_ov_unused;
    assign w_ov_unused = r_ovflag;
`endif

endmodule

// File: tb/tb_carry_alu_n.sv
// Directed self-checking bench for carry_alu_n at WIDTH=16 (overflow flag checked
// when CARRY_ALU_OVERFLOW_EN is defined).
module tb_carry_alu_n;

    logic        aclk = 1'b0;
    logic        areset;
    logic        rx_enable;
    logic        rx_strobe;
    logic        rx_write;
    logic        rx_carryflag;
    logic [2:0]  rx_opcode;
    logic [15:0] rx_operand0;
    logic [15:0] rx_operand1;
    logic [15:0] tx_result;
    logic        tx_carryflag;
    logic        tx_zeroflag;
    logic        tx_signflag;
    logic        tx_ready;
`ifdef CARRY_ALU_OVERFLOW_EN
    logic        tx_overflowflag;
`endif

    int n_err = 0;
    int n_chk = 0;
    int lat;

    always #5 aclk = ~aclk;

    carry_alu_n #(.WIDTH(16)) dut (
        .aclk         (aclk),
        .areset       (areset),
        .rx_enable    (rx_enable),
        .rx_strobe    (rx_strobe),
        .rx_write     (rx_write),
        .rx_carryflag (rx_carryflag),
        .rx_opcode    (rx_opcode),
        .rx_operand0  (rx_operand0),
        .rx_operand1  (rx_operand1),
        .tx_result    (tx_result),
        .tx_carryflag (tx_carryflag),
        .tx_zeroflag  (tx_zeroflag),
        .tx_signflag  (tx_signflag),
`ifdef CARRY_ALU_OVERFLOW_EN
        .tx_overflowflag (tx_overflowflag),
`endif
        .tx_ready     (tx_ready)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Issue one request and wait for completion; lat counts edges from acceptance to completion.
    task automatic run_op(input logic [2:0] op, input logic [15:0] a, input logic [15:0] b,
                          input logic cin, input logic wr, input int stall_after,
                          input int stall_len, input bit busy_strobe, output int lat_o);
        @(negedge aclk);
        rx_enable    = 1'b1;
        rx_opcode    = op;
        rx_operand0  = a;
        rx_operand1  = b;
        rx_carryflag = cin;
        rx_write     = wr;
        rx_strobe    = 1'b1;
        @(posedge aclk);
        #1;
        rx_strobe = 1'b0;
        lat_o = 1;
        check("ready_low_after_accept", {31'd0, tx_ready}, 32'd0);
        while (!tx_ready && lat_o < 40) begin
            if (stall_len > 0 && lat_o == stall_after) begin
                rx_enable = 1'b0;
                repeat (stall_len) @(posedge aclk);
                #1;
                rx_enable = 1'b1;
                lat_o += stall_len;
            end
            if (busy_strobe && lat_o == 2) begin
                rx_strobe   = 1'b1;
                rx_operand0 = 16'hAAAA;
                rx_opcode   = 3'b111;
            end
            @(posedge aclk);
            #1;
            rx_strobe = 1'b0;
            lat_o++;
        end
        check("completion_timeout", {31'd0, tx_ready}, 32'd1);
    endtask

    task automatic check_flags(input string tag, input logic [15:0] res, input logic c,
                               input logic z, input logic s);
        check({tag, "_result"}, {16'd0, tx_result}, {16'd0, res});
        check({tag, "_carry"}, {31'd0, tx_carryflag}, {31'd0, c});
        check({tag, "_zero"}, {31'd0, tx_zeroflag}, {31'd0, z});
        check({tag, "_sign"}, {31'd0, tx_signflag}, {31'd0, s});
    endtask

    initial begin
        areset       = 1'b1;
        rx_enable    = 1'b0;
        rx_strobe    = 1'b0;
        rx_write     = 1'b0;
        rx_carryflag = 1'b0;
        rx_opcode    = 3'b000;
        rx_operand0  = 16'h0000;
        rx_operand1  = 16'h0000;
        repeat (3) @(posedge aclk);
        #1;
        check_flags("reset", 16'h0000, 1'b0, 1'b0, 1'b0);
        check("reset_ready", {31'd0, tx_ready}, 32'd1);
`ifdef CARRY_ALU_OVERFLOW_EN
        check("reset_ovf", {31'd0, tx_overflowflag}, 32'd0);
`endif
        @(negedge aclk);
        areset = 1'b0;

        run_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check("add_latency", lat, 5);
        check_flags("add_wrap", 16'h0000, 1'b1, 1'b1, 1'b0);

        run_op(3'b010, 16'h0003, 16'h0005, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check_flags("sub_borrow", 16'hFFFE, 1'b1, 1'b0, 1'b1);

        run_op(3'b011, 16'h1000, 16'h0001, 1'b1, 1'b1, 0, 0, 1'b0, lat);
        check_flags("sbb", 16'h0FFE, 1'b0, 1'b0, 1'b0);

        run_op(3'b001, 16'h00FF, 16'h0F01, 1'b1, 1'b1, 0, 0, 1'b0, lat);
        check_flags("adc_xslice", 16'h1001, 1'b0, 1'b0, 1'b0);

        run_op(3'b010, 16'h1234, 16'h1234, 1'b0, 1'b0, 0, 0, 1'b0, lat);
        check_flags("cmp_nowrite", 16'h1001, 1'b0, 1'b1, 1'b0);

        run_op(3'b000, 16'h8000, 16'h8000, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check_flags("add_carry", 16'h0000, 1'b1, 1'b1, 1'b0);

        run_op(3'b100, 16'hF0F0, 16'h0FF0, 1'b1, 1'b1, 0, 0, 1'b0, lat);
        check_flags("and", 16'h00F0, 1'b0, 1'b0, 1'b0);

        run_op(3'b110, 16'hFFFF, 16'h0F0F, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check_flags("xor", 16'hF0F0, 1'b0, 1'b0, 1'b1);
`ifdef CARRY_ALU_OVERFLOW_EN
        check("xor_ovf", {31'd0, tx_overflowflag}, 32'd0);
`endif

        run_op(3'b101, 16'h1200, 16'h0034, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check_flags("or", 16'h1234, 1'b0, 1'b0, 1'b0);

        run_op(3'b111, 16'hFFFF, 16'h8001, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check_flags("pass", 16'h8001, 1'b0, 1'b0, 1'b1);

        run_op(3'b000, 16'h1234, 16'h1111, 1'b0, 1'b1, 2, 3, 1'b0, lat);
        check("stall_latency", lat, 8);
        check_flags("stall", 16'h2345, 1'b0, 1'b0, 1'b0);

        run_op(3'b000, 16'h0001, 16'h0002, 1'b0, 1'b1, 0, 0, 1'b1, lat);
        check("busy_strobe_latency", lat, 5);
        check_flags("busy_strobe", 16'h0003, 1'b0, 1'b0, 1'b0);
        @(posedge aclk);
        #1;
        check("busy_strobe_not_queued", {31'd0, tx_ready}, 32'd1);

`ifdef CARRY_ALU_OVERFLOW_EN
        run_op(3'b000, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check_flags("add_ovf", 16'h8000, 1'b0, 1'b0, 1'b1);
        check("add_ovf_flag", {31'd0, tx_overflowflag}, 32'd1);
        run_op(3'b110, 16'h7FFF, 16'h0001, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        check("xor_ovf_clear", {31'd0, tx_overflowflag}, 32'd0);
`endif

        // Reset in the middle of an operation: nothing from it may appear.
        run_op(3'b000, 16'hFFFF, 16'h0001, 1'b0, 1'b1, 0, 0, 1'b0, lat);
        @(negedge aclk);
        rx_opcode   = 3'b111;
        rx_operand1 = 16'h5555;
        rx_write    = 1'b1;
        rx_strobe   = 1'b1;
        @(posedge aclk);
        #1;
        rx_strobe = 1'b0;
        @(posedge aclk);
        #1;
        areset = 1'b1;
        #1;
        check_flags("reset_mid", 16'h0000, 1'b0, 1'b0, 1'b0);
        check("reset_mid_ready", {31'd0, tx_ready}, 32'd1);
        @(negedge aclk);
        areset = 1'b0;
        repeat (6) @(posedge aclk);
        #1;
        check("reset_mid_no_commit", {16'd0, tx_result}, 32'h0000);
        check("reset_mid_ready_hold", {31'd0, tx_ready}, 32'd1);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
